// File: rtl/fifo_wptr_full_pkg.sv
// Shared FIFO constants and Gray-code helpers, reused by the write- and read-side
// pointer blocks.
package fifo_wptr_full_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int DEPTH_DEF     = 2 ** ADDR_SIZE_DEF;
  localparam int AF_MARGIN_DEF = 1;

  // Helpers work on a wide container; callers size-cast the result to their width.
  localparam int PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return (b >> 1'b1) ^ b;
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side FIFO pointer bus: write request and synchronized read pointer in,
// address, Gray pointer and status flags out.
interface fifo_wptr_full_if
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) ();

  logic                 winc;
  logic [ADDR_SIZE:0]   wq2_rptr;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wptr;
  logic                 wfull;
  logic                 walmost_full;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 wovf;

  modport master (
    output winc, wq2_rptr,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, wq2_rptr,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

endinterface

// File: rtl/fifo_wptr_full_gray_counter.sv
// Binary + Gray register pair with an increment enable; exposes next-state values
// so the parent can register flags at the same edge as the pointer.
module gray_counter
  import fifo_wptr_full_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-2:0] o_addr,
  output logic [W-1:0] o_gray,
  output logic [W-1:0] o_bin_next,
  output logic [W-1:0] o_gray_next
);

  logic [W-1:0] r_bin;
  logic [W-1:0] r_gray;
  logic [W-1:0] w_bin_next;
  logic [W-1:0] w_gray_next;

  assign w_bin_next  = r_bin + {{(W-1){1'b0}}, i_inc};
  assign w_gray_next = W'(bin2gray(ptr_max_t'(w_bin_next)));

  // Pointer pair register; Gray copy is a flop so it can cross domains cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
    end
  end

  assign o_addr      = r_bin[W-2:0];
  assign o_gray      = r_gray;
  assign o_bin_next  = w_bin_next;
  assign o_gray_next = w_gray_next;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full logic of an async FIFO: Gray write pointer,
// full / almost-full flags, occupancy estimate and sticky overflow.
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int AF_MARGIN = AF_MARGIN_DEF
) (
  input logic             clk,
  input logic             rst,
  fifo_wptr_full_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int PW    = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic                 w_accept;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [PW-1:0]        w_gray;
  logic [PW-1:0]        w_bin_next;
  logic [PW-1:0]        w_gray_next;
  logic [PW-1:0]        w_rptr_full;
  logic [PW-1:0]        w_rbin;
  logic [PW-1:0]        w_level_next;
  logic                 w_full_next;
  logic                 w_af_next;

  logic                 r_full;
  logic                 r_af;
  logic [PW-1:0]        r_level;
  logic                 r_ovf;

  assign w_accept = bus.winc & ~r_full;

  gray_counter #(.W(PW)) u_wptr (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_accept),
    .o_addr      (w_addr),
    .o_gray      (w_gray),
    .o_bin_next  (w_bin_next),
    .o_gray_next (w_gray_next)
  );

  // Full when the next write pointer equals the read pointer one lap ahead.
  assign w_rptr_full  = {~bus.wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], bus.wq2_rptr[ADDR_SIZE-2:0]};
  assign w_full_next  = (w_gray_next == w_rptr_full);
  assign w_rbin       = PW'(gray2bin(ptr_max_t'(bus.wq2_rptr)));
  assign w_level_next = w_bin_next - w_rbin;
  assign w_af_next    = (w_level_next >= AF_THRESH);

  // Status flags, registered alongside the pointer; overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_level <= w_level_next;
      r_ovf   <= r_ovf | (bus.winc & r_full);
    end
  end

  assign bus.waddr        = w_addr;
  assign bus.wptr         = w_gray;
  assign bus.wfull        = r_full;
  assign bus.walmost_full = r_af;
  assign bus.wlevel       = r_level;
  assign bus.wovf         = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ADDR_SIZE=2, AF_MARGIN=1): directed vectors
// push hand-computed expectations, a negedge monitor pops and compares.
module tb_fifo_wptr_full;

  logic clk;
  logic rst;

  fifo_wptr_full_if #(.ADDR_SIZE(2)) bus ();

  fifo_wptr_full #(.ADDR_SIZE(2), .AF_MARGIN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         idx;
    logic [2:0] wptr;
    logic [1:0] waddr;
    logic       full;
    logic       af;
    logic [2:0] level;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h, expected %0h", idx, name, act, req);
    end
  endtask

  // Monitor: outputs are stable at the falling edge, half a cycle after the update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wptr",         e.idx, {5'd0, bus.wptr},         {5'd0, e.wptr});
        chk("waddr",        e.idx, {6'd0, bus.waddr},        {6'd0, e.waddr});
        chk("wfull",        e.idx, {7'd0, bus.wfull},        {7'd0, e.full});
        chk("walmost_full", e.idx, {7'd0, bus.walmost_full}, {7'd0, e.af});
        chk("wlevel",       e.idx, {5'd0, bus.wlevel},       {5'd0, e.level});
        chk("wovf",         e.idx, {7'd0, bus.wovf},         {7'd0, e.ovf});
      end
    end
  end

  // Drive one cycle of inputs and record what the outputs must be after that edge.
  task automatic cyc(input logic r, input logic w, input logic [2:0] rp,
                     input logic [2:0] ep, input logic [1:0] ea, input logic ef,
                     input logic eaf, input logic [2:0] el, input logic eo);
    exp_t e;
    rst          = r;
    bus.winc     = w;
    bus.wq2_rptr = rp;
    @(posedge clk);
    #1;
    e.idx = vec; e.wptr = ep; e.waddr = ea; e.full = ef;
    e.af = eaf; e.level = el; e.ovf = eo;
    exp_q.push_back(e);
    vec++;
  endtask

  initial begin
    rst          = 1'b1;
    bus.winc     = 1'b0;
    bus.wq2_rptr = 3'b000;

    //   rst   winc  rptr     wptr    addr   full  af    level ovf
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    // fill four slots
    cyc(1'b0, 1'b1, 3'b000, 3'b001, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b011, 2'd2, 1'b0, 1'b0, 3'd2, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b010, 2'd3, 1'b0, 1'b1, 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0);
    // write while full: pointer holds, overflow sticks
    cyc(1'b0, 1'b1, 3'b000, 3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b1);
    // read side frees one slot
    cyc(1'b0, 1'b0, 3'b001, 3'b110, 2'd0, 1'b0, 1'b1, 3'd3, 1'b1);
    cyc(1'b0, 1'b0, 3'b001, 3'b110, 2'd0, 1'b0, 1'b1, 3'd3, 1'b1);
    // reset, then eight writes with reader trailing by one: full lap of the pointer
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b001, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b001, 3'b011, 2'd2, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b011, 3'b010, 2'd3, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b010, 3'b110, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b110, 3'b111, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b111, 3'b101, 2'd2, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b101, 3'b100, 2'd3, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b100, 3'b000, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    // refill from wbin=8 (wrapped to 0) against rptr 0
    cyc(1'b0, 1'b1, 3'b000, 3'b001, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b011, 2'd2, 1'b0, 1'b0, 3'd2, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b010, 2'd3, 1'b0, 1'b1, 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b110, 2'd0, 1'b1, 1'b1, 3'd4, 1'b1);
    // reset beats a write while full; outputs hold while reset stays high
    cyc(1'b1, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b1, 3'b011, 3'b000, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b1, 3'b000, 3'b001, 2'd1, 1'b0, 1'b0, 3'd1, 1'b0);

    bus.winc = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4; FIFO depth DEPTH = 2**ADDR_SIZE.
REQ-002 SHALL have parameter AF_MARGIN, default 1; walmost_full asserts when free slots <= AF_MARGIN.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  write-domain clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 winc  input  1  write request for this cycle.
REQ-007 wq2_rptr  input  ADDR_SIZE+1  Gray read pointer, already synchronized into clk domain.
REQ-008 waddr  output  ADDR_SIZE  RAM write address.
REQ-009 wptr  output  ADDR_SIZE+1  registered Gray write pointer, sent to the read-domain two-flop synchronizer.
REQ-010 wfull  output  1  registered full flag.
REQ-011 walmost_full  output  1  registered almost-full flag.
REQ-012 wlevel  output  ADDR_SIZE+1  registered occupancy estimate, range 0..DEPTH.
REQ-013 wovf  output  1  sticky overflow flag.

Function
REQ-014 SHALL keep a binary pointer wbin (ADDR_SIZE+1 bits) and a Gray pointer wptr, both registered.
REQ-015 Write accepted = winc & ~wfull; wbin_next = wbin + accepted, modulo 2**(ADDR_SIZE+1).
REQ-016 wgray_next = (wbin_next >> 1) ^ wbin_next; wptr <= wgray_next every edge.
REQ-017 waddr SHALL be wbin[ADDR_SIZE-1:0], combinational from the register; no extra delay.
REQ-018 wfull <= (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
REQ-019 The write that fills the last slot SHALL assert wfull at the same edge that updates wptr; no wait cycle.
REQ-020 winc while wfull=1 SHALL leave wbin, wptr and waddr unchanged and SHALL set wovf; wovf stays 1 until reset.
REQ-021 rbin = Gray-to-binary of wq2_rptr, combinational. wlevel <= wbin_next - rbin, modulo 2**(ADDR_SIZE+1).
REQ-022 walmost_full <= (wlevel_next >= DEPTH - AF_MARGIN).
REQ-023 Pointer wrap from 2**(ADDR_SIZE+1)-1 to 0 SHALL be seamless; wptr changes exactly one bit per accepted write.
REQ-024 A read freeing space is visible only when wq2_rptr changes. wfull/wlevel SHALL be pessimistic, never optimistic. wfull deasserts at the first edge after wq2_rptr advances.
REQ-025 wptr SHALL come straight from a flop, with no combinational logic after it, so it is glitch-free for crossing domains.

Reset
REQ-026 When rst=1 at a rising edge: wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0; waddr therefore 0.
REQ-027 Reset SHALL take priority over winc at the same edge, including reset mid-operation with wfull=1.
REQ-028 Outputs SHALL hold reset values while rst stays high, whatever winc and wq2_rptr do.

Structure
REQ-029 The shared FIFO package SHALL hold the ADDR_SIZE/DEPTH constants and the bin2gray/gray2bin functions; the read-side pointer block reuses them.
REQ-030 One sub-module, gray_counter (binary + Gray register pair with an increment enable), is natural. The full, level and overflow logic stays in fifo_wptr_full.

Verification (ADDR_SIZE=2, AF_MARGIN=1, Gray codes 0..7 = 000,001,011,010,110,111,101,100)
REQ-031 rst=1 one cycle, then winc=0 -> wptr=000, waddr=0, wfull=0, wlevel=0, wovf=0.
REQ-032 wq2_rptr=000, winc=1 for 4 cycles -> wptr 001,011,010,110; waddr 1,2,3,0; walmost_full=1 after 3rd edge; wfull=1 and wlevel=4 after 4th edge.
REQ-033 Full, winc=1 one more cycle -> wptr stays 110, waddr stays 0, wovf=1.
REQ-034 Full, wq2_rptr=001 -> next edge wfull=0, wlevel=3, walmost_full=1; wovf stays 1.
REQ-035 rptr tracks writes (occupancy 1), 8 writes total -> wptr returns to 000; each step changes one bit; wfull never asserts.
REQ-036 wfull=1, rst=1 for one edge with winc=1 -> all outputs return to reset values, wovf=0; the next write gives wptr=001.
